rr_mux4_stream: RTL and testbench
=================================

// Module: rr_mux4_stream
//
// PURPOSE
//   Sequential front end for the 4:1 mux datapath.
//   - Four valid/ready input channels of W-bit data.
//   - A round-robin scheduler picks one channel per cycle and generates the 2-bit mux select.
//   - The selected word lands in a one-entry output register with valid/ready handshake.
//   - Turns the combinational 4:1 select into a fair, back-pressured stream stage.
//
// PARAMETERS
//   W        4    data width of every input channel and of out_data
//
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst_n      in   1      asynchronous reset, active-low
//   in_valid   in   4      per-channel valid; bit i qualifies in_data<i>
//   in_data0   in   W      channel 0 data
//   in_data1   in   W      channel 1 data
//   in_data2   in   W      channel 2 data
//   in_data3   in   W      channel 3 data
//   in_ready   out  4      per-channel ready; at most one bit set (one-hot or zero)
//   out_valid  out  1      output register holds a word
//   out_data   out  W      registered selected word
//   out_src    out  2      index of the channel that produced out_data
//   out_ready  in   1      downstream accepts out_data when out_valid=1
//
// BEHAVIOUR
//   Reset (clock and reset are fixed)
//   - One clock; reset is asynchronous and active-low.
//   - rst_n=0 forces, immediately and without a clock edge:
//     out_valid=0, out_data=0, out_src=0, priority pointer ptr=0.
//   - in_ready=0 while rst_n=0.
//   - Reset mid-transfer discards the held word; no partial state survives.
//
//   State
//   - ptr[1:0]: highest-priority channel for the next grant.
//   - Output register: out_valid, out_data, out_src.
//
//   Load enable
//   - load_en = !out_valid | out_ready (register empty or draining this cycle).
//
//   Arbitration (combinational, same cycle)
//   - Search order: ptr, ptr+1, ptr+2, ptr+3, all mod 4.
//   - g = first channel in that order with in_valid=1; any = |in_valid.
//   - in_ready[g] = load_en & any; all other in_ready bits are 0.
//   - in_ready never depends on out_valid of a later cycle.
//   - in_ready must not combinationally depend on in_data.
//
//   Transfer at the clock edge
//   - Input transfer on channel i when in_valid[i] & in_ready[i].
//   - If load_en & any:
//     out_data <= in_data<g>, out_src <= g, out_valid <= 1, ptr <= g+1 mod 4 (3 wraps to 0).
//   - Else if out_valid & out_ready: out_valid <= 0; out_data, out_src and ptr unchanged.
//   - Else: all state holds.
//   - Simultaneous drain and load: the new word replaces the old one in the same edge.
//     Sustained throughput is 1 word/cycle.
//
//   Timing and ordering
//   - Latency: 1 cycle from input transfer to out_valid.
//   - While out_valid=1 and out_ready=0: out_data and out_src are stable and in_ready=0000.
//   - Fairness: with all channels continuously valid, each channel is granted exactly once per 4 grants.
//   - ptr advances only on a grant; idle cycles do not rotate it.
//   - A channel dropping in_valid before its grant is allowed; it is simply skipped.
//
// TESTING
//   1. Hold rst_n=0 with in_valid=1111 -> out_valid=0, out_src=0, in_ready=0000.
//   2. After reset, only ch2 valid with data 4'hA, out_ready=1
//      -> in_ready=0100 in the same cycle; next cycle out_valid=1, out_data=4'hA, out_src=2; ptr=3.
//   3. in_valid=1111 held, data 1/2/3/4 on ch0..3, out_ready=1
//      -> out_src 0,1,2,3,0,... one per cycle; out_data 1,2,3,4,1.
//   4. out_valid=1 and out_ready=0 for 3 cycles with in_valid=1111
//      -> in_ready=0000 and out_data stable; raise out_ready -> next grant starts at ptr.
//   5. ptr=3, in_valid=1001 -> ch3 granted, ptr wraps to 0; next cycle ch0 granted.
//   6. Drop rst_n asynchronously between edges while out_valid=1
//      -> out_valid=0 immediately; after release, first grant searches from ch0.

Source files
------------

// File: rtl/rr_mux4_stream_if.sv
// Stream bundle for the round-robin 4:1 mux stage: four valid/ready inputs
// and one registered valid/ready output carrying the source index.
interface rr_mux4_stream_if #(
  parameter int W = 4
);
  logic [3:0]   in_valid;
  logic [W-1:0] in_data0;
  logic [W-1:0] in_data1;
  logic [W-1:0] in_data2;
  logic [W-1:0] in_data3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic         out_ready;

  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/rr_mux4_stream.sv
// Round-robin 4:1 stream mux: fair per-cycle channel grant feeding a
// one-entry output register with valid/ready back-pressure.
module rr_mux4_stream #(
  parameter int W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_mux4_stream_if.slave   bus
);

  logic [1:0]   ptr;
  logic [1:0]   grant;
  logic         any;
  logic         load_en;
  logic         found;
  logic [1:0]   idx;
  logic [W-1:0] sel_data;

  assign any     = |bus.in_valid;
  assign load_en = !bus.out_valid || bus.out_ready;

  // First valid channel searching upward from ptr, wrapping mod 4.
  always_comb begin
    grant = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + k[1:0];
      if (!found && bus.in_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    sel_data = bus.in_data0;
    case (grant)
      2'd0: sel_data = bus.in_data0;
      2'd1: sel_data = bus.in_data1;
      2'd2: sel_data = bus.in_data2;
      2'd3: sel_data = bus.in_data3;
      default: sel_data = bus.in_data0;
    endcase
  end

  // Gated by rst_n so no channel sees ready while the stage is held in reset.
  always_comb begin
    bus.in_ready = 4'b0000;
    if (rst_n && load_en && any) begin
      bus.in_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= 2'd0;
      ptr           <= 2'd0;
    end else if (load_en && any) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= sel_data;
      bus.out_src   <= grant;
      ptr           <= grant + 2'd1;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux4_stream.sv
// Directed bench for rr_mux4_stream: reset, single grant, rotation,
// back-pressure, pointer wrap, idle hold and asynchronous reset mid-transfer.
module tb_rr_mux4_stream;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rr_mux4_stream_if #(.W(W)) bus ();

  rr_mux4_stream #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] s);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    chk({tag, "_data"},  {28'd0, bus.out_data},  {28'd0, d});
    chk({tag, "_src"},   {30'd0, bus.out_src},   {30'd0, s});
  endtask

  int exp_src [5] = '{3, 0, 1, 2, 3};
  int exp_dat [5] = '{4, 1, 2, 3, 4};

  initial begin
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    bus.in_valid = 4'b1111;
    bus.in_data0 = 4'h1;
    bus.in_data1 = 4'h2;
    bus.in_data2 = 4'h3;
    bus.in_data3 = 4'h4;
    bus.out_ready = 1'b0;

    // Reset held with all channels valid
    #12;
    chk_out("rst", 1'b0, 4'h0, 2'd0);
    chk("rst_in_ready", {28'd0, bus.in_ready}, 32'h0);
    #1 rst_n = 1'b1;
    edge_step();

    // Single channel 2 grant
    bus.in_valid  = 4'b0100;
    bus.in_data2  = 4'hA;
    bus.out_ready = 1'b1;
    #1 chk("single_in_ready", {28'd0, bus.in_ready}, 32'h4);
    edge_step();
    chk_out("single", 1'b1, 4'hA, 2'd2);

    // All valid: ptr=3 so rotation starts at channel 3
    bus.in_valid = 4'b1111;
    bus.in_data2 = 4'h3;
    #1 chk("rot_in_ready", {28'd0, bus.in_ready}, 32'h8);
    for (int i = 0; i < 5; i++) begin
      edge_step();
      chk_out("rot", 1'b1, exp_dat[i][3:0], exp_src[i][1:0]);
    end

    // Back-pressure for 3 cycles, ptr=0
    bus.out_ready = 1'b0;
    #1 chk("bp_in_ready0", {28'd0, bus.in_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      edge_step();
      chk_out("bp_hold", 1'b1, 4'h4, 2'd3);
      chk("bp_in_ready", {28'd0, bus.in_ready}, 32'h0);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_in_ready", {28'd0, bus.in_ready}, 32'h1);
    edge_step();
    chk_out("bp_release", 1'b1, 4'h1, 2'd0);

    // Move ptr to 3, then wrap with in_valid=1001
    bus.in_valid = 4'b0100;
    edge_step();
    chk_out("to_ptr3", 1'b1, 4'h3, 2'd2);
    bus.in_valid = 4'b1001;
    #1 chk("wrap_in_ready3", {28'd0, bus.in_ready}, 32'h8);
    edge_step();
    chk_out("wrap_ch3", 1'b1, 4'h4, 2'd3);
    chk("wrap_in_ready0", {28'd0, bus.in_ready}, 32'h1);
    edge_step();
    chk_out("wrap_ch0", 1'b1, 4'h1, 2'd0);

    // Idle drain, ptr must stay at 1
    bus.in_valid = 4'b0000;
    edge_step();
    chk_out("idle_drain", 1'b0, 4'h1, 2'd0);
    edge_step();
    chk_out("idle_hold", 1'b0, 4'h1, 2'd0);
    bus.in_valid = 4'b1111;
    #1 chk("idle_ptr_in_ready", {28'd0, bus.in_ready}, 32'h2);
    edge_step();
    chk_out("idle_grant", 1'b1, 4'h2, 2'd1);

    // Async reset between edges while holding a word (ptr=2)
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 4'h0, 2'd0);
    chk("async_rst_in_ready", {28'd0, bus.in_ready}, 32'h0);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk("post_rst_in_ready", {28'd0, bus.in_ready}, 32'h1);
    edge_step();
    chk_out("post_rst", 1'b1, 4'h1, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
